// File: rtl/grid_readout.sv
// grid_readout: snapshots an N*N life grid on request and streams it out
// one N-bit row per valid/ready handshake, row 0 first.
module grid_readout #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*N-1:0]       grid,
    input  logic                 capture,
    input  logic                 clr_overrun,
    output logic [N-1:0]         row_data,
    output logic [$clog2(N)-1:0] row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 busy,
    output logic                 overrun
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N*N-1:0] shadow;
    logic [IW-1:0]  cnt;
    logic [IW-1:0]  cnt_next;
    logic           load;
    logic           overrun_next;
    logic           accept;
    logic           last_accept;
    logic [N-1:0]   rows [N];

    // Next-state decode: frame sequencing, snapshot load and overrun tracking.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        load         = 1'b0;
        overrun_next = overrun;
        accept       = (state == SEND) && row_ready;
        last_accept  = accept && (cnt == LAST);
        // Clear first so a coincident dropped capture below wins.
        if (clr_overrun) begin
            overrun_next = 1'b0;
        end
        case (state)
            IDLE: begin
                if (capture) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (cnt != LAST) begin
                        cnt_next = cnt + 1'b1;
                    end else if (capture) begin
                        // Back-to-back frame: restart without a gap.
                        load     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end
                // A capture that cannot start a frame is dropped and flagged.
                if (capture && !last_accept) begin
                    overrun_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, row counter and sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            overrun <= overrun_next;
        end
    end

    // Shadow copy of the grid, so the datapath can keep evolving mid-frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= grid;
        end
    end

    // Split the shadow vector into rows for indexed selection.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            rows[r] = shadow[r*N +: N];
        end
    end

    // Output decode depends only on registered state, never on row_ready.
    assign row_valid   = (state == SEND);
    assign busy        = row_valid;
    assign row_idx     = row_valid ? cnt : '0;
    assign row_data    = row_valid ? rows[cnt] : '0;
    assign frame_start = row_valid && (cnt == '0);
    assign frame_end   = row_valid && (cnt == LAST);

endmodule

// File: tb/tb_grid_readout.sv
// tb_grid_readout: table-driven and randomized checks of grid_readout
// against a row-queue reference model.
module tb_grid_readout;
    logic         clk;
    logic         reset;
    logic [255:0] grid;
    logic         capture;
    logic         clr_overrun;
    logic [15:0]  row_data;
    logic [3:0]   row_idx;
    logic         row_valid;
    logic         row_ready;
    logic         frame_start;
    logic         frame_end;
    logic         busy;
    logic         overrun;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [255:0] GLIDER = 256'h0000e00000;

    grid_readout #(.N(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .grid        (grid),
        .capture     (capture),
        .clr_overrun (clr_overrun),
        .row_data    (row_data),
        .row_idx     (row_idx),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [24:0] dut_v;
    assign dut_v = {row_valid, row_idx, row_data, frame_start, frame_end, busy, overrun};

    // Reference model: the frame still to be delivered, as a queue of rows.
    typedef struct {
        logic [3:0]  idx;
        logic [15:0] data;
    } row_t;
    row_t mq[$];
    logic m_ovr;

    function automatic logic [24:0] pack(input logic v, input logic [3:0] idx,
                                         input logic [15:0] data, input logic ovr);
        return {v, idx, data, v && (idx == 4'd0), v && (idx == 4'd15), v, ovr};
    endfunction

    function automatic logic [24:0] model_vec();
        if (mq.size() == 0) return pack(1'b0, 4'd0, 16'd0, m_ovr);
        return pack(1'b1, mq[0].idx, mq[0].data, m_ovr);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic model_fill(input logic [255:0] g);
        row_t e;
        mq.delete();
        for (int r = 0; r < 16; r++) begin
            e.idx  = 4'(r);
            e.data = g[16*r +: 16];
            mq.push_back(e);
        end
    endtask

    task automatic model_edge(input logic cap, input logic clr, input logic rdy,
                              input logic [255:0] g);
        bit was_busy = (mq.size() > 0);
        bit accept   = was_busy && rdy;
        bit last     = accept && (mq.size() == 1);
        bit set      = 1'b0;
        if (accept) void'(mq.pop_front());
        if (cap) begin
            if (!was_busy || last) model_fill(g);
            else set = 1'b1;
        end
        if (set) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rgrid();
        logic [255:0] g;
        for (int i = 0; i < 8; i++) g[32*i +: 32] = $urandom;
        return g;
    endfunction

    // One clock cycle: drive inputs at the falling edge, compare, advance.
    task automatic step(input logic cap, input logic clr, input logic rdy,
                        input logic [255:0] g, input string name);
        capture     = cap;
        clr_overrun = clr;
        row_ready   = rdy;
        grid        = g;
        check(name, 32'(dut_v), 32'(model_vec()));
        @(posedge clk);
        model_edge(cap, clr, rdy, g);
        @(negedge clk);
    endtask

    typedef struct {
        logic        cap;
        logic        clr;
        logic        rdy;
        logic [1:0]  gsel;
        logic        valid;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        ovr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [255:0] gsel_grid(input logic [1:0] s);
        case (s)
            2'd0:    return GLIDER;
            2'd1:    return '1;
            default: return 256'h1;
        endcase
    endfunction

    task automatic tpush(input logic cap, input logic clr, input logic rdy, input logic [1:0] gs,
                         input logic v, input logic [3:0] idx, input logic [15:0] d,
                         input logic ovr);
        vec_t e;
        e.cap = cap; e.clr = clr; e.rdy = rdy; e.gsel = gs;
        e.valid = v; e.idx = idx; e.data = d; e.ovr = ovr;
        tbl.push_back(e);
    endtask

    initial begin
        logic [15:0] d;
        reset       = 1'b0;
        capture     = 1'b0;
        clr_overrun = 1'b0;
        row_ready   = 1'b0;
        grid        = rgrid();
        model_reset();
        #1;
        check("reset_initial", 32'(dut_v), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1, rgrid(), "idle_after_reset");

        // Glider frame with backpressure at row 5, grid changed to all-ones
        // during the frame, and a dropped capture at row 7.
        tpush(1, 0, 1, 0, 0, 0, 16'h0000, 0);
        for (int r = 0; r < 16; r++) begin
            d = (r == 1) ? 16'h00E0 : 16'h0000;
            if (r == 5) begin
                for (int k = 0; k < 3; k++) tpush(0, 0, 0, 1, 1, 4'(r), d, 0);
            end
            tpush((r == 7), 0, 1, 1, 1, 4'(r), d, (r > 7));
        end
        tpush(0, 1, 1, 1, 0, 0, 16'h0000, 1);
        tpush(0, 0, 0, 1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("tbl[%0d]", i), 32'(dut_v),
                  32'(pack(tbl[i].valid, tbl[i].idx, tbl[i].data, tbl[i].ovr)));
            step(tbl[i].cap, tbl[i].clr, tbl[i].rdy, gsel_grid(tbl[i].gsel), "tbl_model");
        end

        // Set/clear collision, then a back-to-back frame with grid = 1.
        step(1'b1, 1'b0, 1'b1, GLIDER, "b2b_start");
        for (int r = 0; r < 16; r++) begin
            step((r == 2) || (r == 15), (r == 2) || (r == 4), 1'b1,
                 (r == 15) ? 256'h1 : rgrid(), "b2b_frame");
            if (r == 2) check("set_wins_over_clear", 32'(overrun), 32'd1);
        end
        check("b2b_row0", {11'd0, busy, overrun, row_idx, row_data},
              {11'd0, 1'b1, 1'b0, 4'd0, 16'h0001});
        for (int r = 0; r < 17; r++) step(1'b0, 1'b0, 1'b1, rgrid(), "b2b_drain");

        // Reset mid-frame at row 9, then a fresh capture.
        step(1'b1, 1'b0, 1'b1, rgrid(), "rst_frame_start");
        for (int r = 0; r < 9; r++) step(1'b0, 1'b0, 1'b1, rgrid(), "rst_frame");
        check("row9_before_reset", 32'(row_idx), 32'd9);
        reset       = 1'b0;
        capture     = 1'($urandom);
        clr_overrun = 1'($urandom);
        row_ready   = 1'($urandom);
        grid        = rgrid();
        #1;
        check("reset_async_midframe", 32'(dut_v), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            capture = 1'b1;
            @(negedge clk);
            check("reset_held", 32'(dut_v), 32'd0);
        end
        reset = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b1, rgrid(), "after_reset_idle");
        step(1'b1, 1'b0, 1'b1, 256'hABCD, "fresh_capture");
        check("fresh_row0", {11'd0, row_valid, row_idx, row_data}, {11'd0, 1'b1, 4'd0, 16'hABCD});
        for (int r = 0; r < 16; r++) step(1'b0, 1'b0, 1'b1, rgrid(), "fresh_drain");

        // Randomized traffic with occasional short asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                #1;
                reset = 1'b0;
                #1;
                check("rand_async_reset", 32'(dut_v), 32'd0);
                #1;
                reset = 1'b1;
                model_reset();
            end
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0), rgrid(), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/grid_readout.md
# grid_readout

Frame readout engine for the 16x16 Game of Life datapath. It captures a snapshot of the 256-bit `grid_evolve` vector on request, then streams it out one 16-bit row per handshake over a valid/ready interface. The datapath is the grid writer; this block is its reader, feeding a display driver or serial link downstream. Snapshotting decouples readout from the datapath, which may keep evolving during a frame.

## Interface
- `N`, default 16: grid side length. Grid vector width is N*N. Row index width is log2(N). Only N=16 is required to be verified.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `grid`  in  256  current grid from the datapath. Row r occupies bits [16r+15:16r].
- `capture`  in  1  single-cycle request to snapshot `grid` and start a frame.
- `clr_overrun`  in  1  clears the sticky `overrun` flag.
- `row_data`  out  16  row payload. `row_data[c]` = snapshot bit 16r+c. Forced to 0 when `row_valid` = 0.
- `row_idx`  out  4  index r of the row being presented. Forced to 0 in IDLE.
- `row_valid`  out  1  row payload is valid.
- `row_ready`  in  1  downstream accepts the row.
- `frame_start`  out  1  equals `row_valid` && (`row_idx` = 0).
- `frame_end`  out  1  equals `row_valid` && (`row_idx` = 15).
- `busy`  out  1  a frame is in progress (state SEND).
- `overrun`  out  1  sticky: a capture was dropped because a frame was in progress.

## Operation
- FSM states:
  - IDLE: `busy` = 0, `row_valid` = 0.
  - SEND: `busy` = 1, `row_valid` = 1.
- IDLE with `capture` = 1:
  - Latch `grid` into the 256-bit shadow register.
  - Set row counter to 0.
  - Go to SEND.
- SEND, row accepted (`row_valid` && `row_ready` at a clock edge):
  - Row < 15: increment the counter.
  - Row = 15 and `capture` = 0: go to IDLE.
  - Row = 15 and `capture` = 1: back-to-back frame. Re-snapshot `grid`, set counter to 0, stay in SEND. `overrun` is not set.
- SEND, no acceptance: `row_data`, `row_idx` and the shadow register hold unchanged. No row is skipped or repeated.
- `capture` in SEND in any other cycle is ignored and sets `overrun` = 1.
- `overrun` update rules:
  - Cleared when `clr_overrun` = 1.
  - If set and clear coincide, set wins.
- Changes on `grid` during SEND never affect output data.
- All outputs are derived from registered state plus `row_ready`-independent decode. There is no combinational path from `row_ready` to `row_valid`.

## Timing
- Reset (`reset` = 0), applied asynchronously:
  - State goes to IDLE; shadow register and row counter go to 0; `overrun` = 0.
  - All outputs are 0 immediately, without waiting for a clock edge.
- Reset asserted mid-frame aborts the frame. The partial frame is never resumed.
- Capture latency: `capture` sampled at edge k puts row 0 valid in the cycle after edge k.
- Throughput with `row_ready` held 1: one row per cycle, so a frame is 16 cycles.
- `busy` falls at the edge that accepts row 15 (unless a back-to-back capture occurs).
- The earliest next capture from IDLE is accepted in the cycle `busy` is first 0.
- `capture` held high for multiple cycles:
  - The first cycle starts the frame.
  - Each subsequent cycle in SEND that does not coincide with row-15 acceptance sets `overrun`.
- `overrun` and `busy` update on the same edges as the FSM.

## Test plan
- **Reset values.** Assert `reset` = 0 mid-simulation with random inputs → all outputs 0 asynchronously. After release: `busy` = 0, `row_valid` = 0.
- **Glider frame, no backpressure.**
  - Stimulus: `grid` = 256'h0000e00000, one-cycle `capture`, `row_ready` = 1.
  - Response: 16 consecutive valid cycles, `row_idx` 0..15. Row 1 = 16'h00E0, all other rows 16'h0000. `frame_start` is high only at idx 0, `frame_end` only at idx 15. `busy` is low the cycle after idx 15.
- **Backpressure and snapshot isolation.**
  - Stimulus: `row_ready` = 0 for 3 cycles at row 5; `grid` set to all-ones during the frame.
  - Response: idx 5 and its data stay stable for 3 cycles. The frame continues with original data and rows 0..15 each appear exactly once.
- **Overrun.**
  - Stimulus: `capture` pulse while row 7 is presented.
  - Response: frame unaffected, `overrun` = 1 and stays 1. A `clr_overrun` pulse gives 0. A simultaneous `capture` during SEND and `clr_overrun` leaves `overrun` = 1.
- **Back-to-back frames.**
  - Stimulus: `capture` asserted in the cycle row 15 is accepted, with `grid` = 256'h1.
  - Response: next cycle shows row 0 = 16'h0001, `busy` stays 1, `overrun` = 0.
- **Reset mid-frame.**
  - Stimulus: `reset` = 0 while row 9 is presented, then released, then `capture`.
  - Response: outputs 0 during reset. The new frame starts at `row_idx` 0 with freshly captured data.
